// File: rtl/ipsxe_fft_dyn_sreg.sv
// Dynamic-depth tap delay line: shift register with an addressable read tap,
// fill-tracked validity and an optional registered output stage.
module ipsxe_fft_dyn_sreg #(
  parameter int DATA_WIDTH = 10,
  parameter int MAX_DEPTH  = 14,
  parameter int OUT_REG    = 1,
  localparam int ADDR_WIDTH =
    (MAX_DEPTH <= 16) ? 4 : $clog2(MAX_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld
);

  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH + 1)'(MAX_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(MAX_DEPTH - 1);

  logic [DATA_WIDTH-1:0] tap_q [MAX_DEPTH];
  logic [DATA_WIDTH-1:0] tap_d [MAX_DEPTH];
  logic [ADDR_WIDTH:0]   fill_q;
  logic [ADDR_WIDTH:0]   fill_d;
  logic [ADDR_WIDTH-1:0] eaddr;
  logic [DATA_WIDTH-1:0] q;
  logic                  vld_raw;

  always_comb begin
    tap_d = tap_q;
    if (clken) begin
      tap_d[0] = din;
      for (int i = 1; i < MAX_DEPTH; i++) begin
        tap_d[i] = tap_q[i-1];
      end
    end
  end

  // Taps carry no reset so they can map onto SRL/distributed RAM.
  always_ff @(posedge clk) begin
    tap_q <= tap_d;
  end

  always_comb begin
    fill_d = fill_q;
    if (clken && (fill_q != DEPTH)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  always_comb begin
    eaddr = LAST;
    if ({1'b0, addr} < DEPTH) begin
      eaddr = addr;
    end
  end

  assign q       = tap_q[eaddr];
  assign vld_raw = fill_q > {1'b0, eaddr};

  if (OUT_REG != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  vld_q;
    logic                  vld_d;

    always_comb begin
      dout_d = dout_q;
      vld_d  = vld_q;
      if (clken) begin
        dout_d = q;
        vld_d  = vld_raw;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        dout_q <= dout_d;
        vld_q  <= vld_d;
      end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
  end else begin : g_comb
    assign dout     = q;
    assign dout_vld = vld_raw;
  end

endmodule
